// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// Optional subtract path: SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 32;

  function automatic int sa_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fsm_fa.sv
// Single combinational 1-bit full-adder cell.
// Shared by every bit position of the serial adder.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first.
// Build option SERIAL_ADDER_SUB_EN adds the sub_en port (A-B).
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_en,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             busy
);

  localparam int CW = sa_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] w_sum_nx;
  logic             r_carry;
  logic [CW-1:0]    r_bit_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_sub;
  logic             w_accept;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub_en;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept = in_valid && in_ready;

  fa_bit_cell u_fa (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_nx = w_s;
    end else begin : g_wn
      assign w_sum_nx = {w_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_RUN;
      ST_RUN:  if (r_bit_cnt == LAST) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    sum_out   = out_valid ? r_sum_sh : '0;
    cout      = out_valid ? r_carry : 1'b0;
  end

  // Subtract is A + ~B + 1, so the carry seeds to 1 and cin is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_a_sh    <= a_in;
      r_b_sh    <= w_sub ? ~b_in : b_in;
      r_carry   <= w_sub ? 1'b1 : cin;
      r_bit_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh    <= r_a_sh >> 1;
      r_b_sh    <= r_b_sh >> 1;
      r_sum_sh  <= w_sum_nx;
      r_carry   <= w_co;
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench: three widths (1, 8, 13) against an arithmetic model.
// Lane 1 (WIDTH=8) also runs the directed cases.
module tb_serial_adder_fsm;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] a_in      [3];
  logic [31:0] b_in      [3];
  logic        cin_in    [3];
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub_in    [3];
`endif
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] sum_o     [3];
  logic        cout_o    [3];
  logic        busy_o    [3];
  logic [0:0]  s_w1;
  logic [7:0]  s_w8;
  logic [12:0] s_w13;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt  [3];
  int   done_cnt [3];
  exp_t exp_q    [3][$];
  exp_t cur      [3];
  logic last_hs  [3];
  logic prev_ov  [3];
  logic rnd_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sum_o[0] = {31'b0, s_w1};
  assign sum_o[1] = {24'b0, s_w8};
  assign sum_o[2] = {19'b0, s_w13};

  serial_adder_fsm #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_in(a_in[0][0:0]), .b_in(b_in[0][0:0]), .cin(cin_in[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_en(sub_in[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum_out(s_w1), .cout(cout_o[0]), .busy(busy_o[0])
  );

  serial_adder_fsm #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_in(a_in[1][7:0]), .b_in(b_in[1][7:0]), .cin(cin_in[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_en(sub_in[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum_out(s_w8), .cout(cout_o[1]), .busy(busy_o[1])
  );

  serial_adder_fsm #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_in(a_in[2][12:0]), .b_in(b_in[2][12:0]), .cin(cin_in[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_en(sub_in[2]),
`endif
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum_out(s_w13), .cout(cout_o[2]), .busy(busy_o[2])
  );

  function automatic int lw(input int l);
    return (l == 0) ? 1 : (l == 1) ? 8 : 13;
  endfunction

  // Reference: plain modular arithmetic on the lane width.
  function automatic exp_t model(input int l, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci,
                                 input logic sb);
    exp_t e;
    longint unsigned m, av, bv, s;
    int w;
    w  = lw(l);
    m  = (64'd1 << w) - 64'd1;
    av = {32'b0, a} & m;
    bv = {32'b0, b} & m;
    if (sb) begin
      e.sum  = 32'((av - bv) & m);
      e.cout = (av >= bv);
    end else begin
      s      = av + bv + {63'b0, ci};
      e.sum  = 32'(s & m);
      e.cout = s[w];
    end
    e.due = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int l,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane=%0d got=%h want=%h t=%0t",
               nm, l, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input int l,
                      input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane=%0d got=%b want=%b t=%0t",
               nm, l, act, exp, $time);
    end
  endtask

  // Called in the posedge+1 phase; returns just after the accepting edge.
  task automatic do_op(input int l, input logic [31:0] a,
                       input logic [31:0] b, input logic ci,
                       input logic sb);
    exp_t e;
    int   n;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in[l] = sb;
`else
    sb = 1'b0;
`endif
    a_in[l]     = a;
    b_in[l]     = b;
    cin_in[l]   = ci;
    in_valid[l] = 1'b1;
    n = 0;
    while (!in_ready[l] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout lane=%0d", l);
      in_valid[l] = 1'b0;
      return;
    end
    e = model(l, a, b, ci, sb);
    e.due = cyc + 1 + lw(l);
    exp_q[l].push_back(e);
    @(posedge clk); #1;
    acc_cnt[l]++;
    in_valid[l] = 1'b0;
    a_in[l]     = $urandom;
    b_in[l]     = $urandom;
    cin_in[l]   = 1'($urandom);
  endtask

  task automatic expect_res(input int l, input logic [31:0] s,
                            input logic c);
    int n;
    n = 0;
    while (!out_valid[l] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("res_valid", l, out_valid[l], 1'b1);
    chk("res_sum", l, sum_o[l], s);
    chk1("res_cout", l, cout_o[l], c);
    @(posedge clk); #1;
  endtask

  task automatic chk_rst(input int l);
    chk1("rst_in_ready", l, in_ready[l], 1'b1);
    chk1("rst_out_valid", l, out_valid[l], 1'b0);
    chk("rst_sum", l, sum_o[l], 32'h0);
    chk1("rst_cout", l, cout_o[l], 1'b0);
    chk1("rst_busy", l, busy_o[l], 1'b0);
  endtask

  task automatic rand_lane(input int l, input int nops);
    for (int i = 0; i < nops; i++) begin
      in_valid[l] = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      do_op(l, $urandom, $urandom, 1'($urandom), 1'($urandom));
    end
  endtask

  // Monitor: pops the scoreboard whenever a result appears.
  initial begin
    forever begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        if (!rst_n) begin
          chk1("rst_in_ready", l, in_ready[l], 1'b1);
          chk1("rst_out_valid", l, out_valid[l], 1'b0);
          chk1("rst_busy", l, busy_o[l], 1'b0);
          last_hs[l] = 1'b0;
          prev_ov[l] = 1'b0;
        end else begin
          if (last_hs[l]) done_cnt[l]++;
          chk1("in_ready", l, in_ready[l], acc_cnt[l] == done_cnt[l]);
          chk1("busy", l, busy_o[l], acc_cnt[l] != done_cnt[l]);
          if (out_valid[l]) begin
            if (!prev_ov[l]) begin
              if (exp_q[l].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result lane=%0d sum=%h", l, sum_o[l]);
                cur[l].sum  = sum_o[l];
                cur[l].cout = cout_o[l];
              end else begin
                cur[l] = exp_q[l].pop_front();
                chk("latency", l, 32'(cyc), 32'(cur[l].due));
              end
            end
            chk("sum", l, sum_o[l], cur[l].sum);
            chk1("cout", l, cout_o[l], cur[l].cout);
          end else begin
            chk("idle_sum", l, sum_o[l], 32'h0);
            chk1("idle_cout", l, cout_o[l], 1'b0);
            if (exp_q[l].size() != 0 && cyc > exp_q[l][0].due) begin
              checks++;
              errors++;
              $display("FAIL late_result lane=%0d cyc=%0d due=%0d",
                       l, cyc, exp_q[l][0].due);
              void'(exp_q[l].pop_front());
            end
          end
          last_hs[l] = out_valid[l] && out_ready[l];
          prev_ov[l] = out_valid[l];
        end
      end
    end
  end

  initial begin
    wait (rnd_on);
    forever begin
      @(posedge clk); #1;
      for (int l = 0; l < 3; l++)
        out_ready[l] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int l = 0; l < 3; l++) begin
      in_valid[l]  = 1'b0;
      a_in[l]      = '0;
      b_in[l]      = '0;
      cin_in[l]    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_in[l]    = 1'b0;
`endif
      out_ready[l] = 1'b1;
      acc_cnt[l]   = 0;
      done_cnt[l]  = 0;
      last_hs[l]   = 1'b0;
      prev_ov[l]   = 1'b0;
    end
    #12;
    chk_rst(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1, 32'hFF, 32'h01, 1'b0, 1'b0);
    expect_res(1, 32'h00, 1'b1);
    do_op(1, 32'hA5, 32'h5A, 1'b1, 1'b0);
    expect_res(1, 32'h00, 1'b1);
    do_op(1, 32'h12, 32'h34, 1'b0, 1'b0);
    expect_res(1, 32'h46, 1'b0);

    out_ready[1] = 1'b0;
    do_op(1, 32'h33, 32'h44, 1'b0, 1'b0);
    n = 0;
    while (!out_valid[1] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) begin
      @(posedge clk); #1;
      chk1("bp_in_ready", 1, in_ready[1], 1'b0);
      chk1("bp_valid", 1, out_valid[1], 1'b1);
      chk("bp_sum", 1, sum_o[1], 32'h77);
      chk1("bp_cout", 1, cout_o[1], 1'b0);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk1("bp_rel_in_ready", 1, in_ready[1], 1'b1);
    chk1("bp_rel_valid", 1, out_valid[1], 1'b0);

    do_op(1, 32'hF0, 32'h0F, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk_rst(1);
    exp_q[1].delete();
    acc_cnt[1]  = 0;
    done_cnt[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1, 32'h03, 32'h04, 1'b0, 1'b0);
    expect_res(1, 32'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(1, 32'h05, 32'h07, 1'b0, 1'b1);
    expect_res(1, 32'hFE, 1'b0);
    do_op(1, 32'h07, 32'h05, 1'b1, 1'b1);
    expect_res(1, 32'h02, 1'b1);
`endif

    rnd_on = 1'b1;
    fork
      rand_lane(0, 330);
      rand_lane(1, 334);
      rand_lane(2, 330);
    join

    n = 0;
    while (n < 300 && (exp_q[0].size() + exp_q[1].size()
                       + exp_q[2].size()) != 0) begin
      @(posedge clk); #1;
      n++;
    end
    for (int l = 0; l < 3; l++)
      chk("drain_left", l, 32'(exp_q[l].size()), 32'h0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
